// File: rtl/fir_acc.sv
// Accumulates NUM_PROD signed partial products per FIR output sample, then shifts, range-limits and strobes it out.
// Optional build macro FIR_ACC_SAT_EN: saturate on range overflow (default build wraps to OUT_WIDTH bits).
module fir_acc #(
    parameter int WIDTH     = 16,
    parameter int NUM_PROD  = 4,
    parameter int ACC_WIDTH = 24,
    parameter int OUT_WIDTH = 16,
    parameter int SHIFT     = 4
) (
    input  logic                 iClk12M,
    input  logic                 iRst,
    input  logic                 iClear,
    input  logic                 iMulValid,
    input  logic [WIDTH-1:0]     iMul,
    output logic [OUT_WIDTH-1:0] oFirOut,
    output logic                 oFirValid,
    output logic                 oBusy,
    output logic                 oOvf
);

    localparam int CNT_W = $clog2(NUM_PROD + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_PROD);
    localparam longint OUT_MAX_L = (longint'(1) <<< (OUT_WIDTH - 1)) - longint'(1);
    localparam longint OUT_MIN_L = -(longint'(1) <<< (OUT_WIDTH - 1));
    localparam logic [OUT_WIDTH-1:0] OUT_MAX_V = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] OUT_MIN_V = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t                       state_q, state_d;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0]         out_q, out_d;
    logic                         valid_q, valid_d;
    logic                         busy_q, busy_d;
    logic                         ovf_q, ovf_d;

    logic signed [WIDTH-1:0]      mul_s;
    logic signed [ACC_WIDTH-1:0]  mul_ext_s;
    logic signed [ACC_WIDTH-1:0]  shifted_s;
    logic                         over_s, under_s;
    logic [OUT_WIDTH-1:0]         limited_s;

    assign mul_s     = iMul;
    assign mul_ext_s = ACC_WIDTH'(mul_s);
    assign shifted_s = acc_q >>> SHIFT;
    assign over_s    = longint'(shifted_s) > OUT_MAX_L;
    assign under_s   = longint'(shifted_s) < OUT_MIN_L;

    // Range limiting of the shifted sum
    always_comb begin
`ifdef FIR_ACC_SAT_EN
        if (over_s) begin
            limited_s = OUT_MAX_V;
        end else if (under_s) begin
            limited_s = OUT_MIN_V;
        end else begin
            limited_s = OUT_WIDTH'(shifted_s);
        end
`else
        limited_s = OUT_WIDTH'(shifted_s);
`endif
    end

    // Next-state logic; iClear overrides any product arriving in the same cycle
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        valid_d = 1'b0;
        ovf_d   = ovf_q;
        if (iClear) begin
            state_d = S_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (iMulValid) begin
                        acc_d   = mul_ext_s;
                        cnt_d   = CNT_ONE;
                        state_d = (CNT_ONE == CNT_LAST) ? S_OUT : S_ACC;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_ACC: begin
                    if (iMulValid) begin
                        acc_d   = acc_q + mul_ext_s;
                        cnt_d   = cnt_q + CNT_ONE;
                        state_d = ((cnt_q + CNT_ONE) == CNT_LAST) ? S_OUT : S_ACC;
                    end else begin
                        state_d = S_ACC;
                    end
                end
                S_OUT: begin
                    out_d   = limited_s;
                    valid_d = 1'b1;
                    ovf_d   = ovf_q | over_s | under_s;
                    // A product arriving now opens the next sample without a bubble
                    if (iMulValid) begin
                        acc_d   = mul_ext_s;
                        cnt_d   = CNT_ONE;
                        state_d = (CNT_ONE == CNT_LAST) ? S_OUT : S_ACC;
                    end else begin
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign busy_d = (state_d == S_ACC);

    // State and output registers
    always_ff @(posedge iClk12M or posedge iRst) begin
        if (iRst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    assign oFirOut   = out_q;
    assign oFirValid = valid_q;
    assign oBusy     = busy_q;
    assign oOvf      = ovf_q;

endmodule

// File: tb/tb_fir_acc.sv
// Self-checking bench for fir_acc: two instances (SHIFT=0 and SHIFT=4) against a sample-level reference model.
module tb_fir_acc;

    localparam int NP = 4;

    logic        clk;
    logic        rst;
    logic        clr;
    logic        mv;
    logic [15:0] mul;
    logic [15:0] out0, out1;
    logic        val0, val1, busy0, busy1, ovf0, ovf1;

    int errors = 0;
    int checks = 0;

    // Reference model: running sum of the open sample and a completed sample awaiting output
    longint            m_sum;
    int                m_cnt;
    bit                m_pend;
    longint            m_pend_sum;
    logic signed [15:0] e_out [2];
    logic               e_val [2];
    logic               e_ovf [2];
    logic               e_busy;
    int                 shifts [2] = '{0, 4};

    fir_acc #(.WIDTH(16), .NUM_PROD(NP), .ACC_WIDTH(24), .OUT_WIDTH(16), .SHIFT(0)) dut0 (
        .iClk12M(clk), .iRst(rst), .iClear(clr), .iMulValid(mv), .iMul(mul),
        .oFirOut(out0), .oFirValid(val0), .oBusy(busy0), .oOvf(ovf0)
    );

    fir_acc #(.WIDTH(16), .NUM_PROD(NP), .ACC_WIDTH(24), .OUT_WIDTH(16), .SHIFT(4)) dut1 (
        .iClk12M(clk), .iRst(rst), .iClear(clr), .iMulValid(mv), .iMul(mul),
        .oFirOut(out1), .oFirValid(val1), .oBusy(busy1), .oOvf(ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic signed [15:0] limit16(input longint s);
`ifdef FIR_ACC_SAT_EN
        if (s > 64'sd32767) return 16'sd32767;
        else if (s < -64'sd32768) return -16'sd32768;
        else return 16'(s);
`else
        return 16'(s);
`endif
    endfunction

    task automatic model_reset();
        m_sum = 0; m_cnt = 0; m_pend = 1'b0; m_pend_sum = 0; e_busy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            e_out[i] = 16'sd0; e_val[i] = 1'b0; e_ovf[i] = 1'b0;
        end
    endtask

    task automatic model_edge(input logic v, input logic signed [15:0] x, input logic c);
        longint s;
        for (int i = 0; i < 2; i++) e_val[i] = 1'b0;
        if (c) begin
            m_sum = 0; m_cnt = 0; m_pend = 1'b0;
            for (int i = 0; i < 2; i++) e_ovf[i] = 1'b0;
        end else begin
            if (m_pend) begin
                for (int i = 0; i < 2; i++) begin
                    s = m_pend_sum >>> shifts[i];
                    e_val[i] = 1'b1;
                    e_out[i] = limit16(s);
                    if (s > 64'sd32767 || s < -64'sd32768) e_ovf[i] = 1'b1;
                end
                m_pend = 1'b0;
            end
            if (v) begin
                m_sum = m_sum + longint'(x);
                m_cnt = m_cnt + 1;
                if (m_cnt == NP) begin
                    m_pend = 1'b1; m_pend_sum = m_sum; m_sum = 0; m_cnt = 0;
                end
            end
        end
        e_busy = (m_cnt != 0);
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_out0"},  $signed(out0), e_out[0]);
        chk({tag, "_val0"},  {31'd0, val0},  {31'd0, e_val[0]});
        chk({tag, "_busy0"}, {31'd0, busy0}, {31'd0, e_busy});
        chk({tag, "_ovf0"},  {31'd0, ovf0},  {31'd0, e_ovf[0]});
        chk({tag, "_out1"},  $signed(out1), e_out[1]);
        chk({tag, "_val1"},  {31'd0, val1},  {31'd0, e_val[1]});
        chk({tag, "_busy1"}, {31'd0, busy1}, {31'd0, e_busy});
        chk({tag, "_ovf1"},  {31'd0, ovf1},  {31'd0, e_ovf[1]});
    endtask

    // One clock: drive inputs, let the edge happen, then compare 1 time unit later
    task automatic cyc(input string tag, input logic v, input logic signed [15:0] x, input logic c);
        mv = v; mul = x; clr = c;
        @(posedge clk);
        model_edge(v, x, c);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic signed [15:0] t2 [4] = '{16'sd100, 16'sd200, -16'sd50, 16'sd10};
        logic signed [15:0] rx;
        logic               rv, rc;

        rst = 1'b1; clr = 1'b0; mv = 1'b0; mul = 16'd0;
        model_reset();
        #12;
        check_all("reset");
        rst = 1'b0;

        // T2: basic sum, pulse two edges after the last product
        for (int i = 0; i < 4; i++) cyc("t2", 1'b1, t2[i], 1'b0);
        cyc("t2_out", 1'b0, 16'sd0, 1'b0);
        chk("t2_sum", $signed(out0), 32'sd260);
        chk("t2_pulse", {31'd0, val0}, 32'sd1);
        cyc("t2_hold", 1'b0, 16'sd0, 1'b0);

        // T3: gaps between products
        for (int i = 0; i < 4; i++) begin
            cyc("t3", 1'b1, t2[i], 1'b0);
            if (i < 3) begin
                for (int g = 0; g < 3; g++) begin
                    cyc("t3_gap", 1'b0, 16'sd0, 1'b0);
                    chk("t3_busy", {31'd0, busy0}, 32'sd1);
                end
            end
        end
        cyc("t3_out", 1'b0, 16'sd0, 1'b0);
        chk("t3_sum", $signed(out0), 32'sd260);
        cyc("t3_hold", 1'b0, 16'sd0, 1'b0);

        // T4: back-to-back samples
        for (int i = 1; i <= 8; i++) begin
            cyc("t4", 1'b1, 16'(i), 1'b0);
            if (i == 5) chk("t4_first", $signed(out0), 32'sd10);
        end
        cyc("t4_out", 1'b0, 16'sd0, 1'b0);
        chk("t4_second", $signed(out0), 32'sd26);
        cyc("t4_hold", 1'b0, 16'sd0, 1'b0);

        // T5: out-of-range sum
        for (int i = 0; i < 4; i++) cyc("t5", 1'b1, 16'sd32767, 1'b0);
        cyc("t5_out", 1'b0, 16'sd0, 1'b0);
`ifdef FIR_ACC_SAT_EN
        chk("t5_sat", $signed(out0), 32'sd32767);
`else
        chk("t5_wrap", $signed(out0), -32'sd4);
`endif
        chk("t5_ovf", {31'd0, ovf0}, 32'sd1);
        cyc("t5_hold", 1'b0, 16'sd0, 1'b0);

        // T1: asynchronous reset in the middle of a sample, away from any clock edge
        cyc("t1_pre", 1'b1, 16'sd5, 1'b0);
        cyc("t1_pre", 1'b1, 16'sd6, 1'b0);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all("t1_async");
        #1;
        rst = 1'b0;

        // T6: abort together with the third product
        cyc("t6", 1'b1, 16'sd7, 1'b0);
        cyc("t6", 1'b1, 16'sd9, 1'b0);
        cyc("t6_clr", 1'b1, 16'sd11, 1'b1);
        cyc("t6_idle", 1'b0, 16'sd0, 1'b0);
        for (int i = 0; i < 4; i++) cyc("t6_next", 1'b1, 16'sd1, 1'b0);
        cyc("t6_out", 1'b0, 16'sd0, 1'b0);
        chk("t6_sum", $signed(out0), 32'sd4);

        // Randomized traffic with gaps, occasional aborts and a mix of small and full-scale products
        for (int n = 0; n < 400; n++) begin
            rv = ($urandom_range(0, 3) != 0);
            rc = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 1) == 0) rx = 16'($urandom);
            else rx = 16'(int'($urandom_range(0, 2000)) - 1000);
            cyc("rand", rv, rx, rc);
        end
        cyc("drain", 1'b0, 16'sd0, 1'b0);
        cyc("drain", 1'b0, 16'sd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
